// File: rtl/multicycle_control_unit_if.sv
// Bundle between the instruction register/memory side and the multi-cycle datapath.
// The master modport is the control unit; the slave modport is whoever drives opcode/mem_ready.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                ir_write;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic                jal_link;
  logic                reg_dst;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_source;
  logic [ALUOP_W-1:0]  alu_op;
  logic [2:0]          branch_type;
  logic                illegal_op;
  logic                instr_done;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           i_or_d, mem_to_reg, alu_src_a, jal_link, reg_dst, alu_src_b, pc_source,
           alu_op, branch_type, illegal_op, instr_done, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           i_or_d, mem_to_reg, alu_src_a, jal_link, reg_dst, alu_src_b, pc_source,
           alu_op, branch_type, illegal_op, instr_done, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-subset controller: fetch/decode/execute/memory/writeback sequencing,
// memory-ready stalls, a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int ALUOP_W    = 4,
  parameter bit EXT_BRANCH = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   ctrl_io
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b001110;
  localparam logic [5:0] OP_BGE   = 6'b010001;
  localparam logic [5:0] OP_BLT   = 6'b010010;
  localparam logic [5:0] OP_BLE   = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4);

  state_e           state_q, state_d;
  logic [5:0]       opcode_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic [5:0]         opIn;
  logic               pcWrite, pcWriteCond, irWrite, regWrite, memRead, memWrite;
  logic               iOrD, memToReg, aluSrcA, jalLink, regDst, retire;
  logic [1:0]         aluSrcB, pcSource;
  logic [ALUOP_W-1:0] aluOp;
  logic [2:0]         branchType;

  assign opIn = 6'(ctrl_io.opcode);

  always_comb begin
    state_d     = state_q;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    irWrite     = 1'b0;
    regWrite    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    iOrD        = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    jalLink     = 1'b0;
    regDst      = 1'b0;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    aluOp       = ALU_ADD;
    branchType  = 3'd0;
    unique case (state_q)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = ctrl_io.mem_ready;
        pcWrite = ctrl_io.mem_ready;
        if (ctrl_io.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        unique case (opIn)
          OP_RTYPE:                        state_d = EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI:        state_d = EXEC_I;
          OP_LW, OP_SW:                    state_d = MEMADR;
          OP_BEQ, OP_BNE:                  state_d = BRANCH;
          OP_BGT, OP_BGE, OP_BLT, OP_BLE:  state_d = EXT_BRANCH ? BRANCH : TRAP;
          OP_J, OP_JAL:                    state_d = JUMP;
          default:                         state_d = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
        if (ctrl_io.mem_ready) state_d = MEMWB;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
        if (ctrl_io.mem_ready) state_d = FETCH;
      end
      MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        state_d  = FETCH;
      end
      EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_FUNCT;
        state_d = ALUWB;
      end
      EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        if (opcode_q == OP_ANDI)     aluOp = ALU_AND;
        else if (opcode_q == OP_ORI) aluOp = ALU_OR;
        state_d = ALUWB;
      end
      ALUWB: begin
        regWrite = 1'b1;
        regDst   = (opcode_q == OP_RTYPE);
        state_d  = FETCH;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        unique case (opcode_q)
          OP_BNE:  branchType = 3'd1;
          OP_BGT:  branchType = 3'd2;
          OP_BGE:  branchType = 3'd3;
          OP_BLT:  branchType = 3'd4;
          OP_BLE:  branchType = 3'd5;
          default: branchType = 3'd0;
        endcase
        state_d = FETCH;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        regWrite = (opcode_q == OP_JAL);
        jalLink  = (opcode_q == OP_JAL);
        state_d  = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    retire = (state_q != FETCH) && (state_d == FETCH);
  end

  // Reset overrides every write enable and the retire pulse regardless of state,
  // so an aborted instruction cannot commit anything in the reset cycle.
  assign ctrl_io.pc_write      = pcWrite & ~reset;
  assign ctrl_io.pc_write_cond = pcWriteCond & ~reset;
  assign ctrl_io.ir_write      = irWrite & ~reset;
  assign ctrl_io.reg_write     = regWrite & ~reset;
  assign ctrl_io.mem_write     = memWrite & ~reset;
  assign ctrl_io.instr_done    = retire & ~reset;
  assign ctrl_io.mem_read      = memRead;
  assign ctrl_io.i_or_d        = iOrD;
  assign ctrl_io.mem_to_reg    = memToReg;
  assign ctrl_io.alu_src_a     = aluSrcA;
  assign ctrl_io.jal_link      = jalLink;
  assign ctrl_io.reg_dst       = regDst;
  assign ctrl_io.alu_src_b     = aluSrcB;
  assign ctrl_io.pc_source     = pcSource;
  assign ctrl_io.alu_op        = aluOp;
  assign ctrl_io.branch_type   = branchType;
  assign ctrl_io.illegal_op    = illegal_q;
  assign ctrl_io.retired       = retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == TRAP);
      if (state_q == DECODE) opcode_q <= opIn;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle controller for the MIPS-subset processor; the successor to the single-cycle opcode decoder. A Moore/Mealy FSM sequences fetch, decode, execute, memory and writeback across cycles, stalls on a memory ready handshake, and traps unsupported opcodes. It also counts retired instructions. It sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface
- OPCODE_W, 6: opcode field width.
- ALUOP_W, 4: ALU operation code width; must be ≥ 3.
- EXT_BRANCH, 1: 1 = BGT/BGE/BLT/BLE legal; 0 = those opcodes trap as illegal.
- CNT_W, 32: retired-instruction counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  IR[31:26]; sampled in DECODE only.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables.
- i_or_d, mem_to_reg, alu_src_a, jal_link  out  1 each  mux selects. jal_link selects reg 31 and PC+4.
- reg_dst  out  1  1 = rd, 0 = rt.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alu_op  out  ALUOP_W  0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR; zero-extended.
- branch_type  out  3  0 EQ, 1 NE, 2 GT, 3 GE, 4 LT, 5 LE.
- illegal_op  out  1  sticky trap flag.
- instr_done  out  1  one-cycle pulse on an instruction's last cycle.
- retired  out  CNT_W  count of completed instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, TRAP.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH until mem_ready=1, then moves to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target precompute).
  - Next state by opcode:
    - 000000 → EXEC_R.
    - 001000, 001100, 001101 → EXEC_I.
    - 100011, 101011 → MEMADR.
    - 000100, 000101 → BRANCH.
    - 001110, 010001, 010010, 010011 → BRANCH if EXT_BRANCH=1, else TRAP.
    - 000010, 000011 → JUMP.
    - Any other opcode → TRAP.
- DECODE also latches an internal 6-bit opcode copy; later states use only this copy.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, FUNCT. Goes to ALUWB with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_op is ADD, AND or OR for ADDI, ANDI, ORI. Goes to ALUWB with reg_dst=0.
- ALUWB: reg_write=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01. branch_type comes from the latched opcode. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. For JAL only, also reg_write=1 and jal_link=1. Goes to FETCH.
- TRAP: illegal_op=1. All enables are 0. Stays in TRAP until reset.
- Any output not listed for a state is 0.
- instr_done=1 in each cycle that transitions to FETCH. retired increments by 1 in that cycle and wraps modulo 2^CNT_W.

## Timing
- Reset:
  - On a clock edge with reset=1: state←FETCH, retired←0, illegal_op←0, latched opcode←0.
  - While reset=1, all write enables and instr_done are forced to 0, whatever the state.
- Reset mid-instruction aborts that instruction. No write enable is asserted after the reset edge until the next FETCH handshake.
- Cycles per instruction with mem_ready held at 1:
  - R-type and I-ALU: 4.
  - LW: 5.
  - SW: 4.
  - Branch, J and JAL: 3.
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- Wait-state rules:
  - mem_read/mem_write and addresses stay stable across wait cycles.
  - ir_write and pc_write fire only in the FETCH cycle where mem_ready=1.
- opcode changes outside DECODE have no effect.

## Test plan
- Reset, then R-type (000000) with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALUWB. reg_write=1 and reg_dst=1 in cycle 4; instr_done in cycle 4; retired=1.
- LW (100011) with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD → 8 cycles total. ir_write is asserted exactly once; mem_to_reg=1 in MEMWB.
- BLE (010011) with EXT_BRANCH=1 → pc_write_cond=1 and branch_type=5 in cycle 3. Same opcode with EXT_BRANCH=0 → illegal_op=1 and no further fetches.
- JAL (000011) → in cycle 3: pc_write=1, pc_source=10, reg_write=1, jal_link=1. J (000010) → same, but reg_write=0.
- Opcode 111111 → TRAP; illegal_op stays high for 20 cycles. Reset → FETCH, illegal_op=0, retired=0.
- Assert reset during MEMWR of SW → mem_write drops to 0 in the reset cycle; after release, FETCH behaves normally and retired stays 0.
